// File: rtl/divider_pkg.sv
// Shared constants and types for the programmable clock divider.
package divider_pkg;

  localparam int MIN_DIV     = 2;
  localparam int DEF_DIV_W   = 20;
  localparam int DEF_DIV_VAL = 20;

  typedef enum logic [1:0] {
    LD_READY   = 2'd0,
    LD_PEND    = 2'd1,
    LD_APPLIED = 2'd2
  } load_state_t;

endpackage

// File: rtl/div_channel.sv
// One divider channel: period counter, pending-divisor register and load handshake.
//
// state      | meaning
// LD_READY   | no divisor pending, Ready = 1, Load is accepted
// LD_PEND    | divisor captured, waiting for a wrap (or idle) to apply it
// LD_APPLIED | divisor applied this edge, Ready returns on the next edge
module div_channel
  import divider_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic             I_CLK,
  input  logic             Rst,
  input  logic [DIV_W-1:0] div_in,
  input  logic             load,
  input  logic             en,
  output logic             ready,
  output logic             o_clk,
  output logic             tick
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] MIN_D   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  load_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_d;
  logic             active, wrap, apply;
  logic             o_clk_d, tick_d;

  always_ff @(posedge I_CLK or posedge Rst) begin
    if (Rst) begin
      state_q <= LD_READY;
      div_q   <= RST_DIV;
      pend_q  <= RST_DIV;
      cnt_q   <= '0;
      o_clk   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      o_clk   <= o_clk_d;
      tick    <= tick_d;
      if (state_q == LD_READY && load) pend_q <= div_in;
    end
  end

  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    active  = en && (div_q >= MIN_D);
    wrap    = active && (cnt_q == div_q - ONE);

    case (state_q)
      LD_READY:   if (load) state_d = LD_PEND;
      LD_PEND:    if (!active || wrap) begin
                    apply   = 1'b1;
                    state_d = LD_APPLIED;
                  end
      LD_APPLIED: state_d = LD_READY;
      default:    state_d = LD_READY;
    endcase

    div_d = apply ? pend_q : div_q;
    cnt_d = (!active || wrap) ? '0 : cnt_q + ONE;
    // ceil(D/2) without a wider intermediate, so D = 2^DIV_W - 1 cannot overflow
    half_d  = (div_d >> 1) + {{(DIV_W-1){1'b0}}, div_d[0]};
    o_clk_d = active && (cnt_d >= half_d);
    tick_d  = wrap;
  end

  assign ready = (state_q == LD_READY);

endmodule

// File: rtl/prog_divider.sv
// Multi-channel programmable clock divider; one independent div_channel per channel.
module prog_divider
  import divider_pkg::*;
#(
  parameter int CH      = 2,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic                I_CLK,
  input  logic                Rst,
  input  logic [CH*DIV_W-1:0] Div_In,
  input  logic [CH-1:0]       Load,
  output logic [CH-1:0]       Ready,
  input  logic [CH-1:0]       En,
  output logic [CH-1:0]       O_CLK,
  output logic [CH-1:0]       Tick
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    div_channel #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_ch (
      .I_CLK (I_CLK),
      .Rst   (Rst),
      .div_in(Div_In[g*DIV_W +: DIV_W]),
      .load  (Load[g]),
      .en    (En[g]),
      .ready (Ready[g]),
      .o_clk (O_CLK[g]),
      .tick  (Tick[g])
    );
  end

endmodule

// File: tb/tb_prog_divider.sv
// Directed bench for prog_divider with a per-cycle expected-output scoreboard.
module tb_prog_divider;

  localparam int CH  = 2;
  localparam int DW  = 20;
  localparam int DEF = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*DW-1:0] div_in;
  logic [CH-1:0]   load, en, ready, o_clk, tick;

  logic [3:0] w_div = 4'd0;
  logic       w_load = 1'b0;
  logic       w_en;
  logic       w_ready, w_o, w_t;

  always #5 clk = ~clk;

  prog_divider #(.CH(CH), .DIV_W(DW), .DEF_DIV(DEF)) u_dut (
    .I_CLK(clk), .Rst(rst), .Div_In(div_in), .Load(load), .Ready(ready),
    .En(en), .O_CLK(o_clk), .Tick(tick)
  );

  // narrow instance: D = 2^DIV_W - 1 from reset
  prog_divider #(.CH(1), .DIV_W(4), .DEF_DIV(15)) u_dut_w (
    .I_CLK(clk), .Rst(rst), .Div_In(w_div), .Load(w_load), .Ready(w_ready),
    .En(w_en), .O_CLK(w_o), .Tick(w_t)
  );

  typedef struct {
    int   ch;
    logic o;
    logic t;
    logic r;
  } exp_t;

  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  longint m_d[CH], m_pend[CH], m_cnt[CH];
  int     m_st[CH];
  int     w_k;
  int     hi, tk;

  task automatic chk(input string tag, input int ch, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s ch%0d observed=%0b expected=%0b", tag, ch, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int ch, input longint v);
    div_in[ch*DW +: DW] = v[DW-1:0];
  endtask

  // expected state after the coming edge, from the inputs currently driven
  task automatic model_step();
    logic   act, wr;
    longint nd, nc;
    for (int i = 0; i < CH; i++) begin
      act = en[i] && (m_d[i] >= 2);
      wr  = act && (m_cnt[i] == m_d[i] - 1);
      nd  = m_d[i];
      case (m_st[i])
        0: if (load[i]) begin
             m_pend[i] = longint'(div_in[i*DW +: DW]);
             m_st[i]   = 1;
           end
        1: if (!act || wr) begin
             nd      = m_pend[i];
             m_st[i] = 2;
           end
        default: m_st[i] = 0;
      endcase
      nc       = (!act || wr) ? 0 : m_cnt[i] + 1;
      m_d[i]   = nd;
      m_cnt[i] = nc;
      sb.push_back('{i, act && (nc >= (nd + 1) / 2), wr, m_st[i] == 0});
    end
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      if (sb.size() == 0) begin
        chk_int("scoreboard_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("o_clk", e.ch, o_clk[e.ch], e.o);
        chk("tick",  e.ch, tick[e.ch],  e.t);
        chk("ready", e.ch, ready[e.ch], e.r);
      end
    end
    w_k++;
    chk("wide_o_clk", 0, w_o, (w_k % 15) >= 8);
    chk("wide_tick",  0, w_t, (w_k % 15) == 0);
  endtask

  // assert reset between edges, check outputs before any edge, release after one edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < CH; i++) begin
      chk("rst_o_clk", i, o_clk[i], 1'b0);
      chk("rst_tick",  i, tick[i],  1'b0);
      chk("rst_ready", i, ready[i], 1'b1);
      m_d[i] = DEF; m_pend[i] = DEF; m_cnt[i] = 0; m_st[i] = 0;
    end
    chk("rst_wide_o", 0, w_o, 1'b0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    w_k = 0;
  endtask

  task automatic wait_ready(input int ch, input int budget);
    for (int n = 0; n < budget && !ready[ch]; n++) cyc();
    chk("ready_wait", ch, ready[ch], 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = '0; load = '0; div_in = '0; w_en = 1'b1;
    do_reset();

    // default divisor from reset
    en = 2'b11;
    hi = 0; tk = 0;
    repeat (45) begin cyc(); hi += int'(o_clk[0]); tk += int'(tick[0]); end
    chk_int("def_high_cycles", hi, 20);
    chk_int("def_ticks", tk, 2);

    // load 7 mid-period, then a rejected load of 3
    set_div(0, 7); load = 2'b01; cyc(); load = '0;
    chk("load_ack", 0, ready[0], 1'b0);
    set_div(0, 3); load = 2'b01; cyc(); load = '0;
    repeat (13) cyc();
    chk("switch_tick", 0, tick[0], 1'b1);
    chk("ready_low_at_switch", 0, ready[0], 1'b0);
    hi = 0; tk = 0;
    repeat (28) begin cyc(); hi += int'(o_clk[0]); tk += int'(tick[0]); end
    chk_int("d7_high_cycles", hi, 12);
    chk_int("d7_ticks", tk, 4);

    // D = 1 then D = 0: silent
    set_div(0, 1); load = 2'b01; cyc(); load = '0;
    wait_ready(0, 20);
    hi = 0; tk = 0;
    repeat (6) begin cyc(); hi += int'(o_clk[0]); tk += int'(tick[0]); end
    set_div(0, 0); load = 2'b01; cyc(); load = '0;
    wait_ready(0, 5);
    repeat (6) begin cyc(); hi += int'(o_clk[0]); tk += int'(tick[0]); end
    chk_int("silent_high", hi, 0);
    chk_int("silent_ticks", tk, 0);

    // D = 4 from idle applies on the next edge
    set_div(0, 4); load = 2'b01; cyc(); load = '0;
    cyc();
    hi = 0; tk = 0;
    repeat (12) begin cyc(); hi += int'(o_clk[0]); tk += int'(tick[0]); end
    chk_int("d4_high_cycles", hi, 6);
    chk_int("d4_ticks", tk, 3);

    // independent channels: ch0 = 5, ch1 = 8, toggle En on ch1
    set_div(0, 5); set_div(1, 8); load = 2'b11; cyc(); load = '0;
    wait_ready(0, 30);
    wait_ready(1, 30);
    repeat (20) cyc();
    en[1] = 1'b0;
    repeat (3) cyc();
    en[1] = 1'b1;
    repeat (3) begin cyc(); chk("ch1_restart_low", 1, o_clk[1], 1'b0); end
    cyc();
    chk("ch1_restart_high", 1, o_clk[1], 1'b1);
    repeat (16) cyc();

    // async reset with a load pending
    set_div(0, 9); load = 2'b01; cyc(); load = '0;
    chk("pend_before_rst", 0, ready[0], 1'b0);
    cyc();
    do_reset();
    hi = 0; tk = 0;
    repeat (40) begin cyc(); hi += int'(o_clk[0]); tk += int'(tick[0]); end
    chk_int("post_rst_high", hi, 20);
    chk_int("post_rst_ticks", tk, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
